collision_scheduler: RTL and testbench

- Time-multiplexes one Mario-vs-enemy bounding-box overlap check across N_ENEMY enemy slots, once per video frame.
- Started by the frame-start pulse from the VGA/frame logic.
- Produces per-enemy kill pulses, a stomp-bounce pulse for the Mario motion controller, and a sticky Mario-death flag for the game FSM.
- Sits between the sprite position registers and the game-state controller.

---
 rtl/collision_scheduler.sv | 166 ++++++++++++++++
 tb/tb_collision_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Scans one Mario-vs-enemy box overlap per cycle after each frame start and
// reports stomps, bounce and sticky death to the game controller.
// Ports: Clk, Reset (async, active low), frame_start, game_clear,
// Mario_X_Pos/Mario_Y_Pos/Mario_Y_Motion, enemy_x_flat/enemy_y_flat,
// enemy_alive -> enemy_kill, stomp_bounce, mario_die, busy, scan_done,
// overrun.
// Option: define STOMP_GRACE_EN for side-hit immunity after a stomp.
module collision_scheduler #(
  parameter int N_ENEMY      = 4,
  parameter int BOX          = 32,
  parameter int GRACE_FRAMES = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_start,
  input  logic                   game_clear,
  input  logic [12:0]            Mario_X_Pos,
  input  logic [12:0]            Mario_Y_Pos,
  input  logic [12:0]            Mario_Y_Motion,
  input  logic [13*N_ENEMY-1:0]  enemy_x_flat,
  input  logic [13*N_ENEMY-1:0]  enemy_y_flat,
  input  logic [N_ENEMY-1:0]     enemy_alive,
  output logic [N_ENEMY-1:0]     enemy_kill,
  output logic                   stomp_bounce,
  output logic                   mario_die,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESOLVE
  } state_t;

  localparam logic [13:0] BOX14 = 14'(BOX);

  state_t             state, state_nx;
  logic [3:0]         idx;
  logic [12:0]        mx, my, mv;
  logic [12:0]        ex, ey;
  logic [N_ENEMY-1:0] kill_pend, sel;
  logic               die_pend;
  logic               alive_sel, hit;
  logic               falling, last, start;
  logic               side_ok;

  always_comb begin
    ex  = '0;
    ey  = '0;
    sel = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (idx == 4'(i)) begin
        ex     = enemy_x_flat[13*i +: 13];
        ey     = enemy_y_flat[13*i +: 13];
        sel[i] = 1'b1;
      end
    end
  end

  // Sums are widened to 14 bits so boxes near 8191 do not wrap.
  assign alive_sel = |(sel & enemy_alive);
  assign hit = alive_sel
    && ({1'b0, mx} < {1'b0, ex} + BOX14)
    && ({1'b0, ex} < {1'b0, mx} + BOX14)
    && ({1'b0, my} < {1'b0, ey} + BOX14)
    && ({1'b0, ey} < {1'b0, my} + BOX14);

  assign falling = (mv != 13'd0) && !mv[12];
  assign last    = idx == 4'(N_ENEMY - 1);
  assign start   = (state == IDLE) && frame_start;
  assign busy    = state != IDLE;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_start) state_nx = SCAN;
      SCAN:    if (last) state_nx = RESOLVE;
      RESOLVE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (game_clear) state_nx = IDLE;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

`ifdef STOMP_GRACE_EN
  logic [3:0] grace;

  assign side_ok = grace == 4'd0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      grace <= 4'd0;
    end else if (game_clear) begin
      grace <= 4'd0;
    end else if (state == RESOLVE && |kill_pend) begin
      grace <= 4'(GRACE_FRAMES);
    end else if (start && grace != 4'd0) begin
      grace <= grace - 4'd1;
    end
  end
`else
  assign side_ok = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx          <= 4'd0;
      mx           <= '0;
      my           <= '0;
      mv           <= '0;
      kill_pend    <= '0;
      die_pend     <= 1'b0;
      enemy_kill   <= '0;
      stomp_bounce <= 1'b0;
      scan_done    <= 1'b0;
      mario_die    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      enemy_kill   <= '0;
      stomp_bounce <= 1'b0;
      scan_done    <= 1'b0;
      if (game_clear) begin
        idx       <= 4'd0;
        kill_pend <= '0;
        die_pend  <= 1'b0;
        mario_die <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (frame_start && state != IDLE) overrun <= 1'b1;
        unique case (state)
          IDLE: begin
            if (start) begin
              mx        <= Mario_X_Pos;
              my        <= Mario_Y_Pos;
              mv        <= Mario_Y_Motion;
              kill_pend <= '0;
              die_pend  <= 1'b0;
              idx       <= 4'd0;
            end
          end
          SCAN: begin
            if (hit) begin
              if (falling && !mario_die) kill_pend <= kill_pend | sel;
              else if (side_ok) die_pend <= 1'b1;
            end
            idx <= last ? 4'd0 : idx + 4'd1;
          end
          RESOLVE: begin
            enemy_kill   <= kill_pend;
            stomp_bounce <= |kill_pend;
            mario_die    <= mario_die | die_pend;
            scan_done    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with hand-computed expectations.
// Ports driven: all DUT inputs; checks latency, kills, death, overrun, clear.
module tb_collision_scheduler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        game_clear = 1'b0;
  logic [12:0] Mario_X_Pos = '0;
  logic [12:0] Mario_Y_Pos = '0;
  logic [12:0] Mario_Y_Motion = '0;
  logic [51:0] enemy_x_flat = '0;
  logic [51:0] enemy_y_flat = '0;
  logic [3:0]  enemy_alive = '0;
  logic [3:0]  enemy_kill;
  logic        stomp_bounce, mario_die, busy, scan_done, overrun;

  int n_chk = 0;
  int n_fail = 0;

  collision_scheduler #(
    .N_ENEMY(4), .BOX(32), .GRACE_FRAMES(8)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .frame_start(frame_start), .game_clear(game_clear),
    .Mario_X_Pos(Mario_X_Pos), .Mario_Y_Pos(Mario_Y_Pos),
    .Mario_Y_Motion(Mario_Y_Motion),
    .enemy_x_flat(enemy_x_flat), .enemy_y_flat(enemy_y_flat),
    .enemy_alive(enemy_alive), .enemy_kill(enemy_kill),
    .stomp_bounce(stomp_bounce), .mario_die(mario_die),
    .busy(busy), .scan_done(scan_done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_enemy(int i, logic [12:0] x, logic [12:0] y);
    enemy_x_flat[13*i +: 13] = x;
    enemy_y_flat[13*i +: 13] = y;
  endtask

  task automatic set_mario(logic [12:0] x, logic [12:0] y, logic [12:0] v);
    Mario_X_Pos = x;
    Mario_Y_Pos = y;
    Mario_Y_Motion = v;
  endtask

  // One frame; lat counts edges after the sampling edge until scan_done.
  task automatic do_frame(output int lat, output logic [3:0] k,
                          output logic sb);
    @(negedge Clk) frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    lat = 0;
    k = '0;
    sb = 1'b0;
    while (!scan_done && lat < 20) begin
      @(posedge Clk);
      #1 lat++;
    end
    k = enemy_kill;
    sb = stomp_bounce;
  endtask

  task automatic clear_game();
    @(negedge Clk) game_clear = 1'b1;
    @(posedge Clk);
    #1 game_clear = 1'b0;
  endtask

  int         lat, cnt;
  logic [3:0] k;
  logic       sb;

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_kill", 32'(enemy_kill), 32'h0);
    check("rst_sb", 32'(stomp_bounce), 32'h0);
    check("rst_die", 32'(mario_die), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(scan_done), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    @(negedge Clk) Reset = 1'b1;

    // Stomp on enemy0
    for (int i = 0; i < 4; i++) set_enemy(i, 13'd2000, 13'd2000);
    set_mario(13'd100, 13'd100, 13'd3);
    set_enemy(0, 13'd120, 13'd110);
    enemy_alive = 4'b0001;
    @(negedge Clk) frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    check("busy_start", 32'(busy), 32'h1);
    cnt = 0;
    while (!scan_done && cnt < 20) begin
      @(posedge Clk);
      #1 cnt++;
    end
    check("stomp_lat", 32'(cnt), 32'd5);
    check("stomp_kill", 32'(enemy_kill), 32'h1);
    check("stomp_sb", 32'(stomp_bounce), 32'h1);
    check("stomp_die", 32'(mario_die), 32'h0);
    @(posedge Clk);
    #1;
    check("stomp_kill_off", 32'(enemy_kill), 32'h0);
    check("stomp_sb_off", 32'(stomp_bounce), 32'h0);
    check("stomp_done_off", 32'(scan_done), 32'h0);
    check("stomp_busy_off", 32'(busy), 32'h0);

    // Side hit kills Mario; sticky, no later kills
    Mario_Y_Motion = 13'd0;
    do_frame(lat, k, sb);
    check("side_lat", 32'(lat), 32'd5);
    check("side_kill", 32'(k), 32'h0);
    check("side_die", 32'(mario_die), 32'h1);
    Mario_Y_Motion = 13'd3;
    for (int f = 0; f < 3; f++) begin
      do_frame(lat, k, sb);
      check("dead_kill", 32'(k), 32'h0);
      check("dead_sb", 32'(sb), 32'h0);
      check("dead_die", 32'(mario_die), 32'h1);
    end
    clear_game();
    check("clr_die", 32'(mario_die), 32'h0);

    // Touching edges do not overlap; dead slot skipped
    Mario_Y_Motion = 13'd0;
    set_enemy(0, 13'd132, 13'd100);
    set_enemy(2, 13'd110, 13'd110);
    enemy_alive = 4'b0001;
    do_frame(lat, k, sb);
    check("touch_lat", 32'(lat), 32'd5);
    check("touch_kill", 32'(k), 32'h0);
    check("touch_die", 32'(mario_die), 32'h0);
    cnt = 0;
    repeat (6) begin
      @(posedge Clk);
      #1 if (scan_done) cnt++;
    end
    check("touch_done_once", 32'(cnt), 32'h0);
    set_enemy(0, 13'd131, 13'd100);
    do_frame(lat, k, sb);
    check("edge131_die", 32'(mario_die), 32'h1);
    clear_game();
    set_enemy(0, 13'd2000, 13'd2000);
    set_enemy(2, 13'd2000, 13'd2000);

    // Near 8191: no wrap either way
    set_mario(13'd8180, 13'd8180, 13'h1FFE);
    set_enemy(1, 13'd10, 13'd10);
    enemy_alive = 4'b0010;
    do_frame(lat, k, sb);
    check("wrap_kill", 32'(k), 32'h0);
    check("wrap_die", 32'(mario_die), 32'h0);
    Mario_Y_Motion = 13'd3;
    set_enemy(1, 13'd8170, 13'd8170);
    do_frame(lat, k, sb);
    check("hi_kill", 32'(k), 32'h2);
    check("hi_sb", 32'(sb), 32'h1);
    check("ovr_before", 32'(overrun), 32'h0);

    // Back-to-back frame_start
    enemy_alive = 4'b0000;
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk);
    @(negedge Clk) frame_start = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(posedge Clk);
      #1 if (scan_done) cnt++;
    end
    check("ovr_scans", 32'(cnt), 32'd1);
    check("ovr_flag", 32'(overrun), 32'h1);
    clear_game();
    check("gc_ovr", 32'(overrun), 32'h0);
    check("gc_die", 32'(mario_die), 32'h0);
    check("gc_busy", 32'(busy), 32'h0);

    // game_clear aborts a scan
    set_mario(13'd100, 13'd100, 13'd3);
    set_enemy(0, 13'd120, 13'd110);
    enemy_alive = 4'b0001;
    @(negedge Clk) frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    @(posedge Clk);
    #1 game_clear = 1'b1;
    @(posedge Clk);
    #1 game_clear = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    cnt = 0;
    repeat (10) begin
      @(posedge Clk);
      #1 if (scan_done || enemy_kill != 4'h0 || stomp_bounce) cnt++;
    end
    check("abort_pulses", 32'(cnt), 32'd0);

    // Reset mid-scan
    @(negedge Clk) frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("rmid_busy", 32'(busy), 32'h0);
    @(negedge Clk) Reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge Clk);
      #1 if (scan_done || enemy_kill != 4'h0 || stomp_bounce) cnt++;
    end
    check("rmid_pulses", 32'(cnt), 32'd0);

`ifdef STOMP_GRACE_EN
    // Stomp, then side hits are ignored for 7 frames, fatal on the 8th
    do_frame(lat, k, sb);
    check("gr_sb", 32'(sb), 32'h1);
    set_enemy(1, 13'd120, 13'd110);
    enemy_alive = 4'b0010;
    Mario_Y_Motion = 13'd0;
    for (int f = 1; f <= 8; f++) begin
      do_frame(lat, k, sb);
      check("gr_die", 32'(mario_die), (f == 8) ? 32'h1 : 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
